// File: rtl/decomp_dict_reconstruct.sv
// Rebuilds 32-bit words from decoded tokens against a 16-entry FIFO dictionary
// that tracks the compressor's dictionary; one-entry valid/ready output register.
module decomp_dict_reconstruct #(
  parameter int unsigned INPUT_WORD = 32,
  parameter int unsigned DICT_ENTRY = 16,
  parameter int unsigned DICT_WORD  = 32
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_flush,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [1:0]                    i_type_matched,
  input  logic                          i_align,
  input  logic [$clog2(DICT_ENTRY)-1:0] i_location,
  input  logic [INPUT_WORD-1:0]         i_literal,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [INPUT_WORD-1:0]         o_word,
  output logic                          o_err
);

  localparam int unsigned LOC_W  = $clog2(DICT_ENTRY);
  localparam int unsigned FILL_W = LOC_W + 1;

  logic [DICT_ENTRY-1:0][DICT_WORD-1:0] dict;
  logic [LOC_W-1:0]                     wr_ptr;
  logic [FILL_W-1:0]                    fill;

  logic [DICT_WORD-1:0]  dict_rd;
  logic [INPUT_WORD-1:0] merged;
  logic                  accept;
  logic                  do_write;
  logic                  bad_ref;

  assign o_ready  = ~i_flush & (~o_valid | i_ready);
  assign accept   = i_valid & o_ready;
  assign do_write = accept & (i_type_matched != 2'b11);
  assign bad_ref  = accept & (i_type_matched != 2'b00) &
                    ({1'b0, i_location} >= fill);
  assign dict_rd  = dict[i_location];

  // Merge reads the pre-edge dictionary, so a same-edge write never bypasses
  always_comb begin
    merged = i_literal;
    case (i_type_matched)
      2'b01:   merged = i_align ? {i_literal[15:0], dict_rd[15:0]}
                                : {dict_rd[31:16], i_literal[15:0]};
      2'b10:   merged = i_align ? {i_literal[7:0], dict_rd[23:0]}
                                : {dict_rd[31:8], i_literal[7:0]};
      2'b11:   merged = dict_rd;
      default: merged = i_literal;
    endcase
  end

  // Dictionary, write pointer, fill level and sticky error
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      dict   <= '0;
      wr_ptr <= '0;
      fill   <= '0;
      o_err  <= 1'b0;
    end else begin
      if (do_write) begin
        dict[wr_ptr] <= merged;
        wr_ptr       <= wr_ptr + LOC_W'(1);
        if (fill != FILL_W'(DICT_ENTRY)) begin
          fill <= fill + FILL_W'(1);
        end
      end
      if (bad_ref) begin
        o_err <= 1'b1;
      end
    end
  end

  // Output register; flush leaves it alone, reset discards any pending word
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid <= 1'b0;
      o_word  <= '0;
    end else if (accept) begin
      o_valid <= 1'b1;
      o_word  <= merged;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule
